wb_rr_arbiter: RTL
==================

# wb_rr_arbiter

Parametrised N-master to single-slave Wishbone B4 classic shared-bus arbiter. Sits between N master agents/cores and one slave and replaces direct point-to-point master–slave wiring. Provides registered round-robin grant, LOCK-held ownership, response routing to the owner only, and an optional bus-timeout watchdog. Tag signals (TGA/TGC/TGD) are not carried by this block.

## Interface

Reset is synchronous and active-high on a single clock, CLK_I; reset port is RST_I.

Parameters:
- N_MASTERS, 4, number of masters; range 2..16
- AW, 32, address width
- DW, 32, data width; multiple of 8
- TIMEOUT, 255, no-response cycles before watchdog ERR; range ≥ 2; used only with the watchdog compiled in

Ports:
- CLK_I  in  1  bus clock
- RST_I  in  1  reset
- m_cyc_i  in  N_MASTERS  per-master CYC_O
- m_stb_i  in  N_MASTERS  per-master STB_O
- m_we_i  in  N_MASTERS  per-master WE_O
- m_lock_i  in  N_MASTERS  per-master LOCK_O
- m_adr_i  in  N_MASTERS*AW  packed ADR_O; master i at [i*AW +: AW]
- m_sel_i  in  N_MASTERS*DW/8  packed SEL_O
- m_dat_i  in  N_MASTERS*DW  packed write data
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  N_MASTERS  ACK_I per master
- m_err_o  out  N_MASTERS  ERR_I per master
- m_rty_o  out  N_MASTERS  RTY_I per master
- s_cyc_o, s_stb_o, s_we_o, s_lock_o  out  1 each  to slave
- s_adr_o  out  AW  to slave
- s_sel_o  out  DW/8  to slave
- s_dat_o  out  DW  write data to slave
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave responses
- gnt_o  out  N_MASTERS  one-hot current owner; 0 when idle

## Operation

- States: IDLE, BUSY (plus TOERR with the watchdog compiled in).
- IDLE: if any m_cyc_i bit is set, pick the first requester searching upward from last_owner+1, modulo N_MASTERS. Register it as owner and go to BUSY.
- Arbitration only happens in IDLE. A request arriving in BUSY waits.
- BUSY:
  - The owner's CYC/STB/WE/LOCK/ADR/SEL/DAT drive the s_* outputs combinationally.
  - s_ack_i, s_err_i and s_rty_i route only to the owner's bit; all other response bits are 0.
- Release: in BUSY, when the owner has m_cyc_i=0 and m_lock_i=0, go to IDLE.
  - LOCK=1 with CYC=0 keeps ownership; s_cyc_o follows the owner's CYC (0 in that case).
- last_owner updates on release. Reset value is N_MASTERS-1, so master 0 wins the first arbitration.
- IDLE outputs: all s_* = 0, gnt_o = 0, all m_ack/err/rty = 0.
- m_dat_o = s_dat_i at all times.
- Reset mid-transaction: on the next edge, go to IDLE and drop all outputs. No response is issued to the interrupted master.
- Outputs after reset: all 0. Internal state: last_owner=N_MASTERS-1, timeout counter 0.

## Timing

- Grant latency: m_cyc_i rises in cycle t → gnt_o and s_cyc_o are high in cycle t+1.
- Response path (slave → owner) is combinational, with zero added latency.
- Handover: release edge → IDLE for exactly 1 cycle → next owner granted. There is 1 dead cycle between owners, even when the same master re-requests.
- Simultaneous requests in IDLE: only one is granted, by round-robin order. The rest stay pending with no loss.

## Configuration

- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each BUSY cycle with s_stb_o=1 and no slave response.
  - It clears on any response, on STB low, or on leaving BUSY.
  - When the count reaches TIMEOUT, enter TOERR for 1 cycle: m_err_o[owner]=1, s_stb_o forced 0, counter cleared. Then return to BUSY.
- Undefined: no counter and no TOERR state. A silent slave stalls the bus indefinitely.

## Test plan

- Single master: m_cyc_i=4'b0100 with a write to 0x10, data 0xDEADBEEF. Expect gnt_o=4'b0100 one cycle later, s_adr_o=0x10, s_dat_o=0xDEADBEEF, and m_ack_o=4'b0100 in the same cycle as s_ack_i.
- Fairness: all four masters request continuously, each holding CYC for 2 cycles. Expect grant order 0,1,2,3,0 with 1 idle cycle between each.
- LOCK hold: master 1 holds LOCK=1 and drops CYC for 3 cycles while master 2 requests. Expect gnt_o to stay at 4'b0010 until LOCK falls, then 1 idle cycle, then 4'b0100.
- Error/retry routing: owner 3 receives s_err_i=1, then s_rty_i=1. Expect only bit 3 of m_err_o/m_rty_o set, and all other bits 0.
- Reset mid-transaction: assert RST_I while master 2 is in BUSY. Expect all outputs 0 on the next cycle. After release, a request from master 0 is granted first.
- Watchdog (WB_ARB_TIMEOUT_EN, TIMEOUT=8): the slave never responds. Expect m_err_o[owner] pulsed 1 cycle, 9 cycles after s_stb_o first rose, with s_stb_o=0 in that cycle. Without the macro, expect no ERR after 1000 cycles.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B4 shared-bus bundle for wb_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding masters plus the single slave.
interface wb_rr_arbiter_if #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
);
    // Master-side request bundle, master i packed at slice i
    logic [N_MASTERS-1:0]        m_cyc_i;
    logic [N_MASTERS-1:0]        m_stb_i;
    logic [N_MASTERS-1:0]        m_we_i;
    logic [N_MASTERS-1:0]        m_lock_i;
    logic [N_MASTERS*AW-1:0]     m_adr_i;
    logic [N_MASTERS*DW/8-1:0]   m_sel_i;
    logic [N_MASTERS*DW-1:0]     m_dat_i;
    // Master-side responses
    logic [DW-1:0]               m_dat_o;
    logic [N_MASTERS-1:0]        m_ack_o;
    logic [N_MASTERS-1:0]        m_err_o;
    logic [N_MASTERS-1:0]        m_rty_o;
    // Slave side
    logic                        s_cyc_o;
    logic                        s_stb_o;
    logic                        s_we_o;
    logic                        s_lock_o;
    logic [AW-1:0]               s_adr_o;
    logic [DW/8-1:0]             s_sel_o;
    logic [DW-1:0]               s_dat_o;
    logic [DW-1:0]               s_dat_i;
    logic                        s_ack_i;
    logic                        s_err_i;
    logic                        s_rty_i;
    // Current owner, one-hot
    logic [N_MASTERS-1:0]        gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_sel_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_sel_o, s_dat_o,
        output gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_sel_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_sel_o, s_dat_o,
        input  gnt_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to one-slave Wishbone B4 classic arbiter with registered round-robin
// grant, LOCK-held ownership and owner-only response routing.
// Optional bus-timeout watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    wb_rr_arbiter_if.slave   bus
);
    localparam int unsigned OW = $clog2(N_MASTERS);
    localparam int unsigned SW = DW / 8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] StToerr = 2'd2;
    localparam int unsigned CW     = $clog2(TIMEOUT + 1);
`endif

    if (N_MASTERS < 2 || N_MASTERS > 16 || (DW % 8) != 0 || TIMEOUT < 2) begin : g_bad_cfg
        $error("wb_rr_arbiter: unsupported parameter set");
    end

    logic [1:0]           state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_q, last_d;
    logic [OW-1:0]        pick;
    logic [N_MASTERS-1:0] owner_oh;
    logic                 owned;
    logic                 busy;
    logic                 release_req;
    logic                 timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
    logic [CW-1:0]        cnt_q, cnt_d;
`endif

    assign owned       = (state_q != StIdle);
    assign busy        = (state_q == StBusy);
    // LOCK keeps ownership even while the owner's CYC is low
    assign release_req = busy & ~bus.m_cyc_i[owner_q] & ~bus.m_lock_i[owner_q];

    // Round-robin search: first requester strictly after last_owner, wrapping
    always_comb begin
        logic        found;
        int unsigned idx;
        logic [OW-1:0] cand;
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            idx  = (32'(last_q) + i) % N_MASTERS;
            cand = OW'(idx);
            if (!found && bus.m_cyc_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Stall counter: counts strobed BUSY cycles with no slave response
    always_comb begin
        cnt_d       = '0;
        timeout_hit = 1'b0;
        if (busy && !release_req && bus.m_stb_i[owner_q] &&
            !(bus.s_ack_i | bus.s_err_i | bus.s_rty_i)) begin
            if (cnt_q == CW'(TIMEOUT)) begin
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stall counter register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic: arbitration only from idle, release back to idle
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (|bus.m_cyc_i) begin
                    owner_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (release_req) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end else if (timeout_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
                    state_d = StToerr;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            StToerr: state_d = StBusy;
`endif
            default: state_d = StIdle;
        endcase
    end

    // State, owner and last-owner registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OW'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Owner mux to the slave and owner-only response routing
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        bus.gnt_o    = owned ? owner_oh : '0;
        bus.s_cyc_o  = owned & bus.m_cyc_i[owner_q];
        bus.s_stb_o  = busy & bus.m_stb_i[owner_q];
        bus.s_we_o   = owned & bus.m_we_i[owner_q];
        bus.s_lock_o = owned & bus.m_lock_i[owner_q];
        bus.s_adr_o  = owned ? bus.m_adr_i[owner_q*AW +: AW] : '0;
        bus.s_sel_o  = owned ? bus.m_sel_i[owner_q*SW +: SW] : '0;
        bus.s_dat_o  = owned ? bus.m_dat_i[owner_q*DW +: DW] : '0;
        bus.m_ack_o  = (busy & bus.s_ack_i) ? owner_oh : '0;
        bus.m_err_o  = (busy & bus.s_err_i) ? owner_oh : '0;
        bus.m_rty_o  = (busy & bus.s_rty_i) ? owner_oh : '0;
`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog error cycle: strobe withdrawn, ERR to the owner
        if (state_q == StToerr) begin
            bus.m_err_o = owner_oh;
        end
`endif
    end

    assign bus.m_dat_o = bus.s_dat_i;

endmodule
